// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types, constants and window decode for the PUF measurement controller
// Contents:
//   puf_state_e  controller state encoding
//   WIN_BASE     shortest measurement window in cycles
//   CHAL_W       challenge (oscillator-pair select) width
//   WIN_CNT_W    width of the phase timer, large enough for the 512-cycle window
//   window_len() window_cfg -> window length in cycles
package puf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } puf_state_e;

    localparam int WIN_BASE  = 64;
    localparam int CHAL_W    = 5;
    localparam int WIN_CNT_W = 10;

    function automatic logic [WIN_CNT_W-1:0] window_len(input logic [1:0] cfg);
        return WIN_CNT_W'(WIN_BASE) << cfg;
    endfunction

endpackage

// File: rtl/puf_measure_ctrl_if.sv
// rtl/puf_measure_ctrl_if.sv - request/response channel between a host and the PUF measurement controller
// Signals:
//   start       host -> ctrl  one-cycle run request
//   seed        host -> ctrl  first challenge of the run
//   window_cfg  host -> ctrl  window length select (64 << window_cfg)
//   resp_ready  host -> ctrl  response accepted
//   busy        ctrl -> host  run in progress
//   resp        ctrl -> host  response byte
//   resp_valid  ctrl -> host  response present
//   tie_flag    ctrl -> host  some challenge had equal counts
//   sat_flag    ctrl -> host  some count reached 8'hFF
// Modports: master = controller side, slave = host side.
interface puf_measure_ctrl_if;
    import puf_pkg::*;

    logic              start;
    logic [CHAL_W-1:0] seed;
    logic [1:0]        window_cfg;
    logic              resp_ready;
    logic              busy;
    logic [7:0]        resp;
    logic              resp_valid;
    logic              tie_flag;
    logic              sat_flag;

    modport master (
        input  start, seed, window_cfg, resp_ready,
        output busy, resp, resp_valid, tie_flag, sat_flag
    );

    modport slave (
        output start, seed, window_cfg, resp_ready,
        input  busy, resp, resp_valid, tie_flag, sat_flag
    );

endinterface

// File: rtl/puf_window_timer.sv
// rtl/puf_window_timer.sv - loadable down-counter timing the CLEAR, RUN and SETTLE phases
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous reset, active-high
//   load      in   load load_val and arm the timer
//   load_val  in   phase length minus one
//   done      out  single-cycle pulse in the last cycle of the loaded phase
module puf_window_timer
    import puf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIN_CNT_W-1:0] load_val,
    output logic                 done
);

    logic [WIN_CNT_W-1:0] cnt_q;
    logic                 armed_q;

    // Loading N-1 makes the phase last N cycles: done fires while the count
    // sits at zero, then the timer disarms so done never repeats.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (load) begin
            cnt_q   <= load_val;
            armed_q <= 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                armed_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign done = armed_q && (cnt_q == '0);

endmodule

// File: rtl/puf_measure_ctrl.sv
// rtl/puf_measure_ctrl.sv - ring-oscillator PUF measurement sequencer producing an NBITS response byte
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active-high
//   bus        if   request/response channel (master modport)
//   count_a/b  in   frozen edge counts of the two oscillator banks
//   osc_en     out  oscillator bank enable
//   cnt_clr    out  edge counter clear
//   mux_sel    out  challenge driven to both bank muxes
module puf_measure_ctrl
    import puf_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int CLR_CYC    = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    puf_measure_ctrl_if.master bus,
    input  logic [7:0]         count_a,
    input  logic [7:0]         count_b,
    output logic               osc_en,
    output logic               cnt_clr,
    output logic [CHAL_W-1:0]  mux_sel
);

    puf_state_e           state_q, state_d;
    logic [2:0]           k_q;
    logic [1:0]           win_cfg_q;
    logic [7:0]           resp_q;
    logic                 resp_valid_q;
    logic                 busy_q;
    logic                 tie_q;
    logic                 sat_q;
    logic                 tmr_load;
    logic                 tmr_done;
    logic [WIN_CNT_W-1:0] tmr_val;
    logic                 last_chal;
    logic                 start_acc;
    logic                 cmp_gt;
    logic                 cmp_tie;
    logic                 cmp_sat;

    assign last_chal = (k_q == 3'(NBITS - 1));
    assign start_acc = (state_q == S_IDLE) && bus.start;

    assign cmp_gt  = count_a > count_b;
    assign cmp_tie = count_a == count_b;
    assign cmp_sat = (count_a == 8'hFF) || (count_b == 8'hFF);

    assign bus.busy       = busy_q;
    assign bus.resp       = resp_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.tie_flag   = tie_q;
    assign bus.sat_flag   = sat_q;

    puf_window_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Every phase-entering transition reloads the timer with the length of
    // the phase being entered.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = WIN_CNT_W'(CLR_CYC - 1);
                end
            end
            S_CLEAR: begin
                if (tmr_done) begin
                    state_d  = S_RUN;
                    tmr_load = 1'b1;
                    tmr_val  = window_len(win_cfg_q) - 1'b1;
                end
            end
            S_RUN: begin
                if (tmr_done) begin
                    state_d  = S_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = WIN_CNT_W'(SETTLE_CYC - 1);
                end
            end
            S_SETTLE: begin
                if (tmr_done) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (last_chal) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = WIN_CNT_W'(CLR_CYC - 1);
                end
            end
            S_DONE: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register. mux_sel itself carries seed + k: it is
    // loaded with seed on start and bumped with k, wrapping at 5 bits.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            osc_en       <= 1'b0;
            cnt_clr      <= 1'b1;
            mux_sel      <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            tie_q        <= 1'b0;
            sat_q        <= 1'b0;
            k_q          <= '0;
            win_cfg_q    <= '0;
        end else begin
            state_q      <= state_d;
            osc_en       <= (state_d == S_RUN);
            cnt_clr      <= (state_d == S_CLEAR);
            resp_valid_q <= (state_d == S_DONE);
            busy_q       <= (state_d != S_IDLE);
            if (start_acc) begin
                win_cfg_q <= bus.window_cfg;
                mux_sel   <= bus.seed;
                k_q       <= '0;
                resp_q    <= '0;
                tie_q     <= 1'b0;
                sat_q     <= 1'b0;
            end
            if (state_q == S_SAMPLE) begin
                resp_q[k_q] <= cmp_gt;
                tie_q       <= tie_q | cmp_tie;
                sat_q       <= sat_q | cmp_sat;
                if (!last_chal) begin
                    k_q     <= k_q + 1'b1;
                    mux_sel <= mux_sel + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// tb/tb_puf_measure_ctrl.sv - scoreboard testbench for puf_measure_ctrl
module tb_puf_measure_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    puf_measure_ctrl_if bus ();
    puf_measure_ctrl_if bus4 ();

    logic       osc_en, cnt_clr, osc_en4, cnt_clr4;
    logic [4:0] mux_sel, mux_sel4;
    logic [7:0] count_a, count_b, count_a4, count_b4;
    logic [7:0] ca_tab [32];
    logic [7:0] cb_tab [32];

    // Oscillator bank model: frozen counts depend only on the selected pair.
    assign count_a  = ca_tab[mux_sel];
    assign count_b  = cb_tab[mux_sel];
    assign count_a4 = ca_tab[mux_sel4];
    assign count_b4 = cb_tab[mux_sel4];

    puf_measure_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .count_a (count_a),
        .count_b (count_b),
        .osc_en  (osc_en),
        .cnt_clr (cnt_clr),
        .mux_sel (mux_sel)
    );

    puf_measure_ctrl #(.NBITS(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus4),
        .count_a (count_a4),
        .count_b (count_b4),
        .osc_en  (osc_en4),
        .cnt_clr (cnt_clr4),
        .mux_sel (mux_sel4)
    );

    typedef struct packed {
        logic [7:0] resp;
        logic       tie;
        logic       sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic predict(input logic [4:0] s, input int nb);
        exp_t       e;
        logic [4:0] m;
        e = '0;
        for (int i = 0; i < nb; i++) begin
            m = s + 5'(i);
            e.resp[i] = ca_tab[m] > cb_tab[m];
            if (ca_tab[m] == cb_tab[m]) e.tie = 1'b1;
            if (ca_tab[m] == 8'hFF || cb_tab[m] == 8'hFF) e.sat = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic fill_alternating();
        for (int m = 0; m < 32; m++) begin
            ca_tab[m] = (m % 2 == 0) ? 8'd100 : 8'd50;
            cb_tab[m] = (m % 2 == 0) ? 8'd50 : 8'd100;
        end
    endtask

    task automatic fill_random();
        for (int m = 0; m < 32; m++) begin
            ca_tab[m] = 8'($urandom_range(0, 254));
            cb_tab[m] = 8'($urandom_range(0, 254));
        end
    endtask

    // One full run on the 8-bit instance: checks latency, per-challenge
    // mux_sel and window length, the response against the scoreboard, then
    // holds resp_ready low for 'hold' cycles with start pulses before
    // completing the handshake (optionally with start in the same cycle).
    task automatic run_one(input logic [4:0] s, input logic [1:0] cfg,
                           input int hold, input logic start_with_ready);
        int         w;
        int         budget;
        int         lat;
        int         run_len;
        int         exp_lat;
        logic       prev_osc;
        logic       got;
        logic [4:0] run_mux;
        logic [4:0] exp_mux;
        logic [4:0] mux_seen[$];
        int         len_seen[$];
        exp_t       e;
        w       = 64 << cfg;
        exp_lat = 8 * (2 + w + 2 + 1) + 1;
        budget  = exp_lat + 40;
        lat = 0; run_len = 0; prev_osc = 1'b0; got = 1'b0; run_mux = '0;
        predict(s, 8);
        @(negedge clk);
        bus.seed = s; bus.window_cfg = cfg; bus.start = 1'b1;
        while (lat < budget) begin
            @(negedge clk);
            bus.start = 1'b0; bus.seed = ~s; bus.window_cfg = ~cfg;
            lat++;
            if (osc_en) begin
                run_len++;
                run_mux = mux_sel;
            end else if (prev_osc) begin
                mux_seen.push_back(run_mux);
                len_seen.push_back(run_len);
                run_len = 0;
            end
            prev_osc = osc_en;
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        e = exp_q.pop_front();
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL resp_valid_seen: got %b want 1 (seed %0d cfg %0d)", got, s, cfg); end
        n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL latency: got %0d want %0d", lat, exp_lat); end
        n_cmp++; if (bus.resp !== e.resp) begin n_err++; $display("FAIL resp: got %h want %h", bus.resp, e.resp); end
        n_cmp++; if (bus.tie_flag !== e.tie) begin n_err++; $display("FAIL tie_flag: got %b want %b", bus.tie_flag, e.tie); end
        n_cmp++; if (bus.sat_flag !== e.sat) begin n_err++; $display("FAIL sat_flag: got %b want %b", bus.sat_flag, e.sat); end
        n_cmp++; if (mux_seen.size() !== 8) begin n_err++; $display("FAIL run_phase_count: got %0d want 8", mux_seen.size()); end
        for (int i = 0; i < mux_seen.size(); i++) begin
            exp_mux = s + 5'(i);
            n_cmp++; if (mux_seen[i] !== exp_mux) begin n_err++; $display("FAIL mux_sel[%0d]: got %0d want %0d", i, mux_seen[i], exp_mux); end
            n_cmp++; if (len_seen[i] !== w) begin n_err++; $display("FAIL osc_en_len[%0d]: got %0d want %0d", i, len_seen[i], w); end
        end
        if (!got) begin
            rst_n = 1'b1;
            @(negedge clk);
            rst_n = 1'b0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            bus.start = i[0];
            bus.resp_ready = 1'b0;
            @(negedge clk);
            n_cmp++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", i, bus.resp_valid); end
            n_cmp++; if (bus.resp !== e.resp) begin n_err++; $display("FAIL hold_resp[%0d]: got %h want %h", i, bus.resp, e.resp); end
            n_cmp++; if ({bus.tie_flag, bus.sat_flag} !== {e.tie, e.sat}) begin n_err++; $display("FAIL hold_flags[%0d]: got %b want %b", i, {bus.tie_flag, bus.sat_flag}, {e.tie, e.sat}); end
        end
        bus.resp_ready = 1'b1;
        bus.start = start_with_ready;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_after_ready busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL idle_after_ready valid: got %b want 0", bus.resp_valid); end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL start_not_accepted busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (osc_en !== 1'b0) begin n_err++; $display("FAIL rst_osc_en: got %b want 0", osc_en); end
        n_cmp++; if (cnt_clr !== 1'b1) begin n_err++; $display("FAIL rst_cnt_clr: got %b want 1", cnt_clr); end
        n_cmp++; if (mux_sel !== 5'd0) begin n_err++; $display("FAIL rst_mux_sel: got %0d want 0", mux_sel); end
        n_cmp++; if (bus.resp !== 8'h00) begin n_err++; $display("FAIL rst_resp: got %h want 00", bus.resp); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if ({bus.tie_flag, bus.sat_flag} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {bus.tie_flag, bus.sat_flag}); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (cnt_clr !== 1'b0) begin n_err++; $display("FAIL release_cnt_clr: got %b want 0", cnt_clr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL release_busy: got %b want 0", bus.busy); end
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; bus.seed = 5'd9; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL first_edge_start busy: got %b want 1", bus.busy); end
        n_cmp++; if (cnt_clr !== 1'b1) begin n_err++; $display("FAIL first_edge_start cnt_clr: got %b want 1", cnt_clr); end
        n_cmp++; if (mux_sel !== 5'd9) begin n_err++; $display("FAIL first_edge_start mux_sel: got %0d want 9", mux_sel); end
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alternating();
        fill_alternating();
        run_one(5'd0, 2'd0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        fill_random();
        run_one(5'd30, 2'd1, 0, 1'b0);
    endtask

    task automatic test_tie_sat();
        for (int m = 0; m < 32; m++) begin
            ca_tab[m] = 8'($urandom_range(0, 99));
            cb_tab[m] = 8'($urandom_range(100, 199));
            if ($urandom_range(0, 1) == 1) begin
                ca_tab[m] = cb_tab[m];
                cb_tab[m] = 8'($urandom_range(0, 99));
            end
        end
        ca_tab[2] = 8'h40; cb_tab[2] = 8'h40;
        cb_tab[5] = 8'hFF;
        run_one(5'd0, 2'd0, 0, 1'b0);
    endtask

    task automatic test_hold();
        fill_random();
        run_one(5'd7, 2'd2, 20, 1'b1);
    endtask

    task automatic test_long_window();
        fill_random();
        run_one(5'd3, 2'd3, 0, 1'b0);
    endtask

    task automatic test_mid_reset();
        int   falls;
        int   run_cnt;
        int   pulses;
        logic prev;
        logic reached;
        fill_alternating();
        falls = 0; run_cnt = 0; prev = 1'b0; reached = 1'b0; pulses = 0;
        @(negedge clk);
        bus.seed = 5'd0; bus.window_cfg = 2'd0; bus.start = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (prev && !osc_en) falls++;
            prev = osc_en;
            if (falls == 3 && osc_en) run_cnt++;
            if (run_cnt == 10) begin
                reached = 1'b1;
                break;
            end
        end
        n_cmp++; if (reached !== 1'b1) begin n_err++; $display("FAIL reach_k3_run: got %b want 1", reached); end
        n_cmp++; if (mux_sel !== 5'd3) begin n_err++; $display("FAIL k3_mux_sel: got %0d want 3", mux_sel); end
        #1 rst_n = 1'b1;
        #1;
        n_cmp++; if (osc_en !== 1'b0) begin n_err++; $display("FAIL abort_osc_en: got %b want 0", osc_en); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b0;
        for (int t = 0; t < 700; t++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL no_partial_resp: got %0d pulses want 0", pulses); end
        run_one(5'd0, 2'd0, 0, 1'b0);
    endtask

    task automatic test_nbits4();
        exp_t e;
        int   lat;
        logic got;
        fill_random();
        predict(5'd12, 4);
        lat = 0; got = 1'b0;
        @(negedge clk);
        bus4.seed = 5'd12; bus4.window_cfg = 2'd0; bus4.start = 1'b1;
        while (lat < 400) begin
            @(negedge clk);
            bus4.start = 1'b0;
            lat++;
            if (bus4.resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        e = exp_q.pop_front();
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL n4_valid_seen: got %b want 1", got); end
        n_cmp++; if (lat !== 277) begin n_err++; $display("FAIL n4_latency: got %0d want 277", lat); end
        n_cmp++; if (bus4.resp !== e.resp) begin n_err++; $display("FAIL n4_resp: got %h want %h", bus4.resp, e.resp); end
        n_cmp++; if (bus4.resp[7:4] !== 4'h0) begin n_err++; $display("FAIL n4_upper_bits: got %h want 0", bus4.resp[7:4]); end
        bus4.resp_ready = 1'b1;
        @(negedge clk);
        bus4.resp_ready = 1'b0;
        n_cmp++; if (bus4.busy !== 1'b0) begin n_err++; $display("FAIL n4_idle: got %b want 0", bus4.busy); end
    endtask

    initial begin
        bus.start = 1'b0; bus.seed = '0; bus.window_cfg = '0; bus.resp_ready = 1'b0;
        bus4.start = 1'b0; bus4.seed = '0; bus4.window_cfg = '0; bus4.resp_ready = 1'b0;
        fill_alternating();
        test_reset();
        test_alternating();
        test_wrap();
        test_tie_sat();
        test_hold();
        test_long_window();
        test_mid_reset();
        test_nbits4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/puf_measure_ctrl.md
PUF_MEASURE_CTRL -- requirements
Module: puf_measure_ctrl

Interface
REQ-001 Parameter NBITS, default 8: response bits per measurement run (range 1..8).
REQ-002 Parameter CLR_CYC, default 2: cycles cnt_clr is held during CLEAR (1..15).
REQ-003 Parameter SETTLE_CYC, default 2: cycles between osc_en fall and count sampling (1..15).
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-007 seed  in  5  first challenge (oscillator-pair select); captured on accepted start.
REQ-008 window_cfg  in  2  window length = 64 << window_cfg cycles (64/128/256/512); captured on accepted start.
REQ-009 count_a, count_b  in  8 each  frozen ring-oscillator counter values from the two PUF banks.
REQ-010 osc_en  out  1  enables both oscillator banks.
REQ-011 cnt_clr  out  1  clears both edge counters.
REQ-012 mux_sel  out  5  challenge driven to both bank muxes.
REQ-013 resp  out  8  response byte; bit k = result of challenge k; bits >= NBITS are 0.
REQ-014 resp_valid  out  1 / resp_ready  in  1  response handshake.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 tie_flag, sat_flag  out  1 each  sticky per run: any challenge with count_a == count_b / any count == 8'hFF.

Function
REQ-017 States: IDLE, CLEAR, RUN, SETTLE, SAMPLE, DONE; registered outputs, Moore.
REQ-018 IDLE -> CLEAR on start; captures seed, window_cfg; clears resp, k, both flags.
REQ-019 CLEAR: cnt_clr = 1, osc_en = 0 for exactly CLR_CYC cycles, then RUN.
REQ-020 RUN: osc_en = 1 for exactly 64 << window_cfg cycles, then SETTLE.
REQ-021 SETTLE: osc_en = 0, cnt_clr = 0 for SETTLE_CYC cycles, then SAMPLE.
REQ-022 SAMPLE (1 cycle): resp[k] = (count_a > count_b); update flags; if k == NBITS-1 -> DONE, else k++ and -> CLEAR.
REQ-023 mux_sel = (seed + k) mod 32, stable from CLEAR entry through SAMPLE; 5-bit wrap-around (seed 30, NBITS 8 -> 30,31,0,..,5).
REQ-024 Tie (equal counts): response bit 0, tie_flag set.
REQ-025 DONE: resp_valid = 1, resp/flags held stable until resp_ready sampled high; then IDLE next cycle.
REQ-026 resp_valid never asserted outside DONE; resp_ready ignored outside DONE.
REQ-027 start while busy is ignored (no queueing, no effect on current run).
REQ-028 start and resp_ready in same DONE cycle: complete handshake, go IDLE; start not accepted.
REQ-029 Total run latency from accepted start to resp_valid = NBITS*(CLR_CYC + W + SETTLE_CYC + 1) + 1 cycles, W = window length.
REQ-030 Window counter width 10 bits; no overflow for max window 512.

Reset
REQ-031 While rst_n = 1: state IDLE, osc_en 0, cnt_clr 1, mux_sel 0, resp 0, resp_valid 0, busy 0, both flags 0.
REQ-032 Reset asserted mid-run aborts immediately; no partial response is ever presented.
REQ-033 After rst_n falls, cnt_clr deasserts on the first clock edge; first start accepted that same cycle.

Structure
REQ-034 Shared package puf_pkg holds state enum, window base (64), window_cfg decode function, challenge width (5).
REQ-035 One sub-module puf_window_timer: loadable down-counter with done pulse, used for CLEAR, RUN and SETTLE durations.
REQ-036 Comparator and response shift/accumulate logic stay in the top controller; no combinational loop through the oscillators in this block.

Verification
REQ-037 Reset mid-RUN (k=3) -> osc_en 0 same cycle, busy 0, resp_valid never pulses, next start runs a full 8-challenge run.
REQ-038 seed 0, window_cfg 0, counts A>B for even k, A<B for odd k -> resp = 8'h55, resp_valid at cycle 8*69+1 = 553.
REQ-039 seed 30 -> mux_sel sequence 30,31,0,1,2,3,4,5 observed in each RUN phase.
REQ-040 count_a = count_b = 8'h40 on k=2, count_b = 8'hFF on k=5 -> resp[2] = 0, tie_flag 1, sat_flag 1.
REQ-041 resp_ready held low 20 cycles in DONE -> resp/resp_valid stable; start pulses ignored; resp_ready high -> IDLE next cycle.
REQ-042 window_cfg 3 -> osc_en high exactly 512 cycles per challenge; NBITS 4 build -> resp[7:4] = 0.
